// File: rtl/adpll_bw_sequencer_if.sv
// Mode-control bundle between the bandwidth sequencer and its environment.
// The master drives the loop enable and the phase-decision stream. The slave
// (the sequencer) drives the filter mode controls and status.
interface adpll_bw_sequencer_if #(
    parameter int unsigned CNT_W = 7
);
    logic             pll_en;
    logic             phase_valid;
    logic             early;
    logic             cold_start_traditional;
    logic             lowbw_pre;
    logic             lowbw1;
    logic             fine_done_traditional;
    logic             lock_detect;
    logic [1:0]       state;
    logic [CNT_W-1:0] flip_count;

    modport master (
        output pll_en, phase_valid, early,
        input  cold_start_traditional, lowbw_pre, lowbw1, fine_done_traditional,
        input  lock_detect, state, flip_count
    );

    modport slave (
        input  pll_en, phase_valid, early,
        output cold_start_traditional, lowbw_pre, lowbw1, fine_done_traditional,
        output lock_detect, state, flip_count
    );
endinterface

// File: rtl/adpll_bw_sequencer.sv
// Loop-bandwidth sequencer for the ADPLL PI filter.
// It counts bang-bang sign flips per window to detect lock. It then walks the
// filter from wide-band acquisition (COLD), through an integrator transfer
// (XFER), into low-bandwidth tracking (LOW).
// Optional feature: define ADPLL_BW_SEQ_UNLOCK_EN to build the loss-of-lock
// fallback from LOW to COLD. Without the macro, LOW is terminal.
module adpll_bw_sequencer #(
    parameter int unsigned WIN_LEN      = 64,
    parameter int unsigned FLIP_THR     = 40,
    parameter int unsigned TRANSFER_CYC = 2,
    parameter int unsigned UNLOCK_RUN   = 8
) (
    input logic                 ref_clk,
    input logic                 fine_done_with_reset,
    adpll_bw_sequencer_if.slave bus
);
    localparam int unsigned CntW  = $clog2(WIN_LEN + 1);
    localparam int unsigned XferW = $clog2(TRANSFER_CYC + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCold = 2'd1,
        StXfer = 2'd2,
        StLow  = 2'd3
    } state_e;

    logic [1:0]       rst_sync_q;
    logic             rst_int;
    state_e           state_q, state_d;
    logic [CntW-1:0]  win_cnt_q, win_cnt_d;
    logic [CntW-1:0]  flip_cnt_q, flip_cnt_d;
    logic [CntW-1:0]  flip_tot;
    logic [XferW-1:0] xfer_cnt_q, xfer_cnt_d;
    logic             prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             flip;
    logic             cold_q, pre_q, low_q, fdt_q;
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
    localparam int unsigned RunW = $clog2(UNLOCK_RUN + 1);
    logic [RunW-1:0]  run_cnt_q, run_cnt_d;
`endif

    // Reset synchronizer: assertion reaches the core at once, release is
    // synchronous. The core comes out of reset once the first stage has cleared.
    always_ff @(posedge ref_clk or posedge fine_done_with_reset) begin
        if (fine_done_with_reset) rst_sync_q <= 2'b11;
        else                      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1] & rst_sync_q[0];

    // Next-state and counter logic; pll_en low overrides everything
    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        flip_cnt_d   = flip_cnt_q;
        xfer_cnt_d   = xfer_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
        run_cnt_d    = run_cnt_q;
`endif
        flip     = prev_valid_q & (bus.early != prev_q);
        flip_tot = flip_cnt_q + CntW'(flip);

        if (!bus.pll_en) begin
            state_d      = StIdle;
            win_cnt_d    = '0;
            flip_cnt_d   = '0;
            xfer_cnt_d   = '0;
            prev_d       = 1'b0;
            prev_valid_d = 1'b0;
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
            run_cnt_d    = '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    state_d      = StCold;
                    win_cnt_d    = '0;
                    flip_cnt_d   = '0;
                    prev_valid_d = 1'b0;
                end
                StCold: begin
                    if (bus.phase_valid) begin
                        prev_d       = bus.early;
                        prev_valid_d = 1'b1;
                        if (win_cnt_q == CntW'(WIN_LEN - 1)) begin
                            // The window closes here, and the last decision's flip counts
                            win_cnt_d  = '0;
                            flip_cnt_d = '0;
                            if (flip_tot >= CntW'(FLIP_THR)) begin
                                state_d      = StXfer;
                                xfer_cnt_d   = '0;
                                prev_valid_d = 1'b0;
                            end
                        end else begin
                            win_cnt_d  = win_cnt_q + 1'b1;
                            flip_cnt_d = flip_tot;
                        end
                    end
                end
                StXfer: begin
                    if (bus.phase_valid) begin
                        if (xfer_cnt_q == XferW'(TRANSFER_CYC - 1)) begin
                            state_d      = StLow;
                            xfer_cnt_d   = '0;
                            prev_valid_d = 1'b0;
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
                            run_cnt_d    = '0;
`endif
                        end else begin
                            xfer_cnt_d = xfer_cnt_q + 1'b1;
                        end
                    end
                end
                StLow: begin
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
                    if (bus.phase_valid) begin
                        prev_d       = bus.early;
                        prev_valid_d = 1'b1;
                        // The run length includes the current decision, so a flip restarts it at 1
                        if (prev_valid_q && !flip) begin
                            run_cnt_d = (run_cnt_q == RunW'(UNLOCK_RUN)) ? run_cnt_q
                                                                         : run_cnt_q + 1'b1;
                        end else begin
                            run_cnt_d = RunW'(1);
                        end
                        if (run_cnt_d == RunW'(UNLOCK_RUN)) begin
                            state_d      = StCold;
                            run_cnt_d    = '0;
                            win_cnt_d    = '0;
                            flip_cnt_d   = '0;
                            prev_valid_d = 1'b0;
                        end
                    end
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counters and registered Moore outputs derived from the next state
    always_ff @(posedge ref_clk or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= StIdle;
            win_cnt_q    <= '0;
            flip_cnt_q   <= '0;
            xfer_cnt_q   <= '0;
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            cold_q       <= 1'b0;
            pre_q        <= 1'b0;
            low_q        <= 1'b0;
            fdt_q        <= 1'b0;
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
            run_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            flip_cnt_q   <= flip_cnt_d;
            xfer_cnt_q   <= xfer_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cold_q       <= (state_d == StCold);
            pre_q        <= (state_d == StXfer) || (state_d == StLow);
            low_q        <= (state_d == StLow);
            fdt_q        <= bus.phase_valid & bus.pll_en & (state_q != StIdle);
`ifdef ADPLL_BW_SEQ_UNLOCK_EN
            run_cnt_q    <= run_cnt_d;
`endif
        end
    end

    assign bus.cold_start_traditional = cold_q;
    assign bus.lowbw_pre              = pre_q;
    assign bus.lowbw1                 = low_q;
    assign bus.lock_detect            = low_q;
    assign bus.fine_done_traditional  = fdt_q;
    assign bus.state                  = state_q;
    assign bus.flip_count             = flip_cnt_q;
endmodule

// File: doc/adpll_bw_sequencer.md
# adpll_bw_sequencer

Loop-bandwidth sequencer sitting directly upstream of the traditional PI loop filter. It watches the per-reference-cycle bang-bang phase decision (`early`), detects frequency/phase lock by counting decision sign flips over a fixed window, and drives the filter's mode controls: `cold_start_traditional`, `lowbw_pre`, `lowbw1`, and the `fine_done_traditional` update strobe. It walks the loop from wide-band acquisition, through a one-shot integrator transfer, into low-bandwidth tracking, and optionally falls back on loss of lock.

## Interface
Parameters:
- `WIN_LEN`, 64: valid decisions per lock-detect window.
- `FLIP_THR`, 40: minimum sign flips in one window to declare lock.
- `TRANSFER_CYC`, 2: valid decisions spent in XFER.
- `UNLOCK_RUN`, 8: consecutive identical decisions that declare loss of lock.

Ports:
- `ref_clk`  in  1  reference clock; all state changes on its rising edge.
- `fine_done_with_reset`  in  1  reset, asynchronous, active-high.
- `pll_en`  in  1  loop enable; combined `reset2 & reset3` domain enable.
- `phase_valid`  in  1  one-cycle strobe marking `early` valid.
- `early`  in  1  BBPD decision: 1 = early, 0 = late.
- `cold_start_traditional`  out  1  wide-band accumulate mode.
- `lowbw_pre`  out  1  low-bandwidth path armed.
- `lowbw1`  out  1  low-bandwidth integrator running (0 = load transfer value).
- `fine_done_traditional`  out  1  filter update strobe.
- `lock_detect`  out  1  high in LOW.
- `state`  out  2  current FSM state encoding.
- `flip_count`  out  $clog2(WIN_LEN+1)  flip count of current window.

## Operation
- States: IDLE=0, COLD=1, XFER=2, LOW=3. All outputs are registered (Moore).
- Outputs by state:
  - IDLE: all 0.
  - COLD: `cold_start_traditional`=1.
  - XFER: `lowbw_pre`=1, `lowbw1`=0.
  - LOW: `lowbw_pre`=1, `lowbw1`=1, `lock_detect`=1.
- IDLE -> COLD when `pll_en`=1.
- `pll_en`=0 in any state forces IDLE on the next edge and clears all counters. This overrides every other transition.
- Window logic, active in COLD only:
  - `win_cnt` counts valid decisions 0..WIN_LEN-1.
  - `flip_count` increments on a valid decision whose `early` differs from the previous valid decision.
  - `prev_valid` is cleared on each state entry. The first decision after entry only loads `prev` and never counts as a flip.
  - On the valid decision with `win_cnt`=WIN_LEN-1, the total flips including that decision are evaluated: if ≥ FLIP_THR -> XFER; else stay in COLD.
  - In both cases `win_cnt` and `flip_count` clear, and `prev` is retained.
- XFER: counts TRANSFER_CYC valid decisions, then -> LOW.
- LOW: tracks `run_cnt`, the number of consecutive valid decisions equal to the previous one.
  - `run_cnt` saturates at UNLOCK_RUN.
  - A flip resets `run_cnt` to 1.
- `fine_done_traditional` is `phase_valid` delayed one `ref_clk`. It is forced 0 in IDLE, and also forced 0 while `pll_en`=0.
- Counters never wrap. `win_cnt` is cleared at WIN_LEN-1. `flip_count` is bounded by WIN_LEN-1.

## Timing
- Reset values: all outputs 0, `state`=IDLE, all counters 0, `prev_valid`=0.
- Reset is asserted asynchronously and released synchronously (two-flop sync inside the block). The first active edge is the second `ref_clk` rise after deassert.
- `pll_en` rise -> `state`=COLD and `cold_start_traditional`=1 one edge later.
- Lock-window decision -> mode outputs change on the same edge that samples the last window decision.
- `fine_done_traditional` lags `phase_valid` by exactly one cycle. Because mode outputs update on the sampling edge, the filter sees the new mode before the strobe.
- Reset asserted mid-operation: outputs drop to 0 immediately, without waiting for a clock.

## Configuration
- Macro `ADPLL_BW_SEQ_UNLOCK_EN`.
- Defined: in LOW, `run_cnt` reaching UNLOCK_RUN -> COLD on that edge. Counters clear and `lock_detect` falls.
- Undefined: `run_cnt` logic is not built, and LOW is terminal until reset or `pll_en`=0.

## Test plan
- Reset and enable: assert reset, then release; hold `pll_en`=1 -> all outputs 0 during reset; `state`=1 and `cold_start_traditional`=1 on the first active edge after release.
- Acquisition: 64 valid decisions with 30 flips -> stays COLD with `flip_count` cleared; next window alternating every decision (63 flips) -> `state`=2, `lowbw_pre`=1, `lowbw1`=0.
- Transfer: 2 valid decisions in XFER -> `state`=3, `lowbw1`=1, `lock_detect`=1; `fine_done_traditional` pulses one cycle after each `phase_valid`.
- Unlock (macro defined): in LOW, 8 consecutive `early`=1 -> `state`=1, `lock_detect`=0. With the macro undefined, the same stimulus leaves `state`=3.
- Override: drop `pll_en` during XFER while `phase_valid`=1 -> `state`=0 next edge, all outputs 0, no `fine_done_traditional` pulse.
- Threshold boundary: window with exactly 40 flips -> XFER; with 39 flips -> stays COLD.
